// File: rtl/apb_regfile_slave.sv
// APB3 completer holding NUM_REGS word registers with programmable wait states.
//
// Ports:
//   aclk, areset          clock, asynchronous active-high reset
//   PSEL/PENABLE/PWRITE   APB control from the upstream bridge
//   PADDR, PWDATA         byte address and write data
//   PRDATA/PREADY/PSLVERR APB response; all zero outside the completing cycle
//   hw_wr_en, hw_wr_data  per-register hardware load (read-only registers only)
//   reg_q                 flattened register contents, reg i at [i*DW +: DW]
//   wr_pulse              one-cycle strobe the cycle after an APB write to reg i commits
module apb_regfile_slave #(
  parameter int unsigned          APB_ADDR_WIDTH = 32,
  parameter int unsigned          DATA_WIDTH     = 32,
  parameter int unsigned          NUM_REGS       = 16,
  parameter int unsigned          WAIT_STATES    = 0,
  parameter logic [NUM_REGS-1:0]  RO_MASK        = '0
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic                           PSEL,
  input  logic [APB_ADDR_WIDTH-1:0]      PADDR,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  input  logic [NUM_REGS-1:0]            hw_wr_en,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_wr_data,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int unsigned BL  = DATA_WIDTH / 8;
  localparam int unsigned LSB = $clog2(BL);
  localparam int unsigned IXW = $clog2(NUM_REGS);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StAccess = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;

  logic [IXW-1:0] idx;
  logic           err_addr, err_ro, err;
  logic           ready;
  logic           commit_wr;

  // Address decode; any bit outside the word-index field makes the access illegal.
  always_comb begin
    idx      = PADDR[LSB +: IXW];
    err_addr = (32'(idx) >= NUM_REGS)
             | (PADDR[LSB-1:0] != '0)
             | (PADDR[APB_ADDR_WIDTH-1:LSB+IXW] != '0);
    err_ro   = PWRITE & ~err_addr & RO_MASK[idx];
    err      = err_addr | err_ro;
  end

  always_comb begin
    ready     = (state_q == StAccess) & PSEL & PENABLE & (cnt_q == 8'd0);
    commit_wr = ready & PWRITE & ~err;
    PREADY    = ready;
    PSLVERR   = ready & err;
    PRDATA    = (ready & ~PWRITE & ~err_addr) ? regs_q[idx] : '0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (PSEL && !PENABLE) begin
          state_d = StAccess;
          cnt_d   = 8'(WAIT_STATES);
        end
      end
      StAccess: begin
        // Dropping PSEL mid-access is a protocol violation; abandon quietly.
        if (!PSEL) begin
          state_d = StIdle;
        end else if (PENABLE) begin
          if (cnt_q == 8'd0) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // RO registers take hardware loads only, RW registers take APB writes only,
  // so the two paths never target the same register.
  always_comb begin
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      regs_d[i]     = regs_q[i];
      wr_pulse_d[i] = commit_wr && (int'(idx) == i);
      if (RO_MASK[i]) begin
        if (hw_wr_en[i]) begin
          regs_d[i] = hw_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end else if (wr_pulse_d[i]) begin
        regs_d[i] = PWDATA;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      wr_pulse_q <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_pulse_q <= wr_pulse_d;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
    wr_pulse = wr_pulse_q;
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Bench for apb_regfile_slave: three instances (0, 3 and 5 wait states) share one bus
// with a private PSEL each. Expected responses come from a register model and are
// queued when a transfer is driven, then popped and compared when PREADY arrives.
module tb_apb_regfile_slave;

  logic         aclk = 1'b0;
  logic         areset;
  logic [2:0]   psel;
  logic         penable, pwrite;
  logic [31:0]  paddr, pwdata;
  logic [31:0]  prdata [3];
  logic [2:0]   pready, pslverr;
  logic [511:0] regq [3];
  logic [15:0]  wrp [3];
  logic [15:0]  hw_en0;
  logic [511:0] hw_data0;
  logic [15:0]  hw_en_off;
  logic [511:0] hw_data_off;

  always #5 aclk = ~aclk;

  apb_regfile_slave #(.WAIT_STATES(0), .RO_MASK(16'h0008)) u_dut0 (
    .aclk(aclk), .areset(areset), .PSEL(psel[0]), .PADDR(paddr), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0]), .hw_wr_en(hw_en0), .hw_wr_data(hw_data0), .reg_q(regq[0]),
    .wr_pulse(wrp[0])
  );

  apb_regfile_slave #(.WAIT_STATES(3)) u_dut3 (
    .aclk(aclk), .areset(areset), .PSEL(psel[1]), .PADDR(paddr), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1]), .hw_wr_en(hw_en_off), .hw_wr_data(hw_data_off), .reg_q(regq[1]),
    .wr_pulse(wrp[1])
  );

  apb_regfile_slave #(.WAIT_STATES(5)) u_dut5 (
    .aclk(aclk), .areset(areset), .PSEL(psel[2]), .PADDR(paddr), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata[2]), .PREADY(pready[2]),
    .PSLVERR(pslverr[2]), .hw_wr_en(hw_en_off), .hw_wr_data(hw_data_off), .reg_q(regq[2]),
    .wr_pulse(wrp[2])
  );

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    bit          err;
    int          waits;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model [3][16];
  bit   [15:0] ro [3];
  int          ws [3];
  int          errors = 0;
  int          checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b0) || (a[31:6] != 26'b0);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the completing edge with PSEL low,
  // so an immediately following call issues its setup with no bubble.
  task automatic apb_xfer(input int d, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input string tag);
    exp_t        e;
    exp_t        p;
    logic [31:0] rd;
    logic        se;
    int          w;
    e.tag   = tag;
    e.err   = addr_bad(a) || (wr && ro[d][a[5:2]]);
    e.waits = ws[d];
    e.rdata = (wr || addr_bad(a)) ? 32'h0 : model[d][a[5:2]];
    sb.push_back(e);
    if (wr && !e.err) model[d][a[5:2]] = wd;
    psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(posedge aclk); #1;
    penable = 1'b1;
    w  = 0;
    rd = 'x;
    se = 1'bx;
    forever begin
      @(negedge aclk);
      if (pready[d]) begin
        rd = prdata[d];
        se = pslverr[d];
        break;
      end
      w++;
      if (w > 300) break;
    end
    @(posedge aclk); #1;
    psel[d] = 1'b0; penable = 1'b0;
    p = sb.pop_front();
    check_eq($sformatf("%s_waits", p.tag), 64'(w), 64'(p.waits));
    check_eq($sformatf("%s_prdata", p.tag), 64'(rd), 64'(p.rdata));
    check_eq($sformatf("%s_pslverr", p.tag), 64'(se), 64'(p.err));
  endtask

  task automatic check_regs(input int d, input string tag);
    for (int i = 0; i < 16; i++) begin
      check_eq($sformatf("%s_d%0d_reg%0d", tag, d, i), 64'(regq[d][i*32 +: 32]),
               64'(model[d][i]));
    end
  endtask

  task automatic zero_model();
    for (int d = 0; d < 3; d++) for (int i = 0; i < 16; i++) model[d][i] = 32'h0;
  endtask

  initial begin
    ro = '{16'h0008, 16'h0000, 16'h0000};
    ws = '{0, 3, 5};
    zero_model();
    areset = 1'b1; psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    hw_en0 = '0; hw_data0 = '0; hw_en_off = '0; hw_data_off = '0;
    #1;
    check_eq("rst_pready", 64'(pready), 64'h0);
    check_eq("rst_pslverr", 64'(pslverr), 64'h0);
    idle(2);
    check_eq("rst_wr_pulse0", 64'(wrp[0]), 64'h0);
    check_regs(0, "rst");
    areset = 1'b0;
    idle(1);

    // Zero wait states: write then read register 2.
    apb_xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, "t1_wr");
    check_eq("t1_wr_pulse", 64'(wrp[0]), 64'h0004);
    idle(1);
    check_eq("t1_wr_pulse_gone", 64'(wrp[0]), 64'h0);
    check_regs(0, "t1");
    apb_xfer(0, 1'b0, 32'h08, 32'h0, "t1_rd");
    check_eq("t1_rd_no_pulse", 64'(wrp[0]), 64'h0);

    // Three wait states.
    apb_xfer(1, 1'b0, 32'h04, 32'h0, "t2_rd0");
    check_eq("t2_no_extra_ready", 64'(pready[1]), 64'h0);
    apb_xfer(1, 1'b1, 32'h04, 32'hA5A5_0F0F, "t2_wr");
    apb_xfer(1, 1'b0, 32'h04, 32'h0, "t2_rd1");

    // Illegal addresses: out of range and misaligned.
    apb_xfer(0, 1'b1, 32'h40, 32'h1111_1111, "t3_wr_oor");
    check_eq("t3_oor_pulse", 64'(wrp[0]), 64'h0);
    apb_xfer(0, 1'b1, 32'h06, 32'h2222_2222, "t3_wr_mis");
    check_eq("t3_mis_pulse", 64'(wrp[0]), 64'h0);
    apb_xfer(0, 1'b0, 32'h40, 32'h0, "t3_rd_oor");
    apb_xfer(0, 1'b0, 32'h0A, 32'h0, "t3_rd_mis");
    apb_xfer(0, 1'b0, 32'h1000_0008, 32'h0, "t3_rd_high");
    check_regs(0, "t3");

    // Read-only register 3, hardware load; hw load on RW reg 2 must be ignored.
    apb_xfer(0, 1'b1, 32'h0C, 32'h1234, "t4_wr_ro");
    check_eq("t4_ro_pulse", 64'(wrp[0]), 64'h0);
    hw_en0 = 16'h000C;
    hw_data0[3*32 +: 32] = 32'h55;
    hw_data0[2*32 +: 32] = 32'h77;
    idle(1);
    hw_en0 = '0;
    model[0][3] = 32'h55;
    check_regs(0, "t4");
    apb_xfer(0, 1'b0, 32'h0C, 32'h0, "t4_rd_ro");

    // Back-to-back: setup issued in the cycle right after PREADY.
    apb_xfer(0, 1'b1, 32'h00, 32'hCAFE_F00D, "t5_wr");
    apb_xfer(0, 1'b0, 32'h00, 32'h0, "t5_rd");
    apb_xfer(1, 1'b1, 32'h3C, 32'h0BAD_C0DE, "t5_wr3");
    apb_xfer(1, 1'b0, 32'h3C, 32'h0, "t5_rd3");

    // Reset in the middle of a five-wait-state write.
    apb_xfer(2, 1'b1, 32'h10, 32'h1111_2222, "t6_pre");
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h14; pwdata = 32'hBAD0_BAD0;
    idle(1);
    penable = 1'b1;
    idle(2);
    areset = 1'b1;
    #1;
    zero_model();
    check_eq("t6_rst_pready", 64'(pready[2]), 64'h0);
    check_eq("t6_rst_pslverr", 64'(pslverr[2]), 64'h0);
    check_eq("t6_rst_prdata", 64'(prdata[2]), 64'h0);
    psel = '0; penable = 1'b0;
    idle(1);
    areset = 1'b0;
    idle(1);
    check_regs(2, "t6");
    check_eq("t6_no_pulse", 64'(wrp[2]), 64'h0);
    apb_xfer(2, 1'b1, 32'h14, 32'h0000_600D, "t6_wr");
    check_eq("t6_wr_pulse", 64'(wrp[2]), 64'h0020);
    apb_xfer(2, 1'b0, 32'h14, 32'h0, "t6_rd");
    check_regs(2, "t6_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
